// File: rtl/core_cluster_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_cluster_ctrl
// Description : Sequences the launch and completion of a cluster of cores.
//               Optional run-cycle timeout is enabled by CLUSTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_cluster_ctrl #(
  parameter int NUM_CORES     = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int TIMEOUT_CYCLS = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic                 busy,
  output logic                 cluster_done,
  output logic [NUM_CORES-1:0] done_mask,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 timed_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] done_mask_q, done_mask_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                 timed_out_q, timed_out_d;

  logic [NUM_CORES-1:0] run_done;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 limit_hit;

  // Done bits of this cycle are folded in so completion is seen without delay.
  assign run_done  = done_mask_q | (core_done & mask_q);
  assign count_inc = (cycle_count_q == {CNT_WIDTH{1'b1}}) ? cycle_count_q
                                                          : cycle_count_q + CNT_WIDTH'(1);

`ifdef CLUSTER_TIMEOUT_EN
  assign limit_hit = (32'(count_inc) >= 32'(TIMEOUT_CYCLS));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLS;
  assign limit_hit      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    done_mask_d   = done_mask_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    case (state_q)
      ST_IDLE: begin
        if (host_start) begin
          mask_d        = core_mask;
          done_mask_d   = '0;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
          state_d       = (core_mask == '0) ? ST_DONE : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if ((core_ready & mask_q) == mask_q) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        done_mask_d   = run_done;
        cycle_count_d = count_inc;
        // Completion wins over a timeout reached in the same cycle.
        if (run_done == mask_q) begin
          state_d = ST_DONE;
        end else if (limit_hit) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      done_mask_q   <= '0;
      cycle_count_q <= '0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      done_mask_q   <= done_mask_d;
      cycle_count_q <= cycle_count_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign core_start   = (state_q == ST_LAUNCH) ? mask_q : '0;
  assign busy         = (state_q != ST_IDLE);
  assign cluster_done = (state_q == ST_DONE);
  assign done_mask    = done_mask_q;
  assign cycle_count  = cycle_count_q;
  assign timed_out    = timed_out_q;

endmodule
`default_nettype wire
